// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // Only the lower bound needs checking; the upper bound is the port width.
  function automatic logic div_legal(input logic [63:0] value);
    return value >= 64'(MIN_DIV);
  endfunction

endpackage

// File: rtl/clk_div_duty.sv
// 50% duty generation: registered high phase plus a half-cycle extension for odd divisors.
module clk_div_duty
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 30
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  state_e           state_d_i,
  input  state_e           state_q_i,
  input  logic [WIDTH-1:0] cnt_d_i,
  input  logic [WIDTH-1:0] cur_div_d_i,
  input  logic [WIDTH-1:0] cur_div_q_i,
  output logic             clk_out_o
);

  logic pos_hi_d;
  logic pos_hi_q;
  logic neg_hi_q;

  // Computed from next-state values so pos_hi_q lines up with cnt_q and tick.
  assign pos_hi_d = (state_d_i != IDLE) && (cnt_d_i < (cur_div_d_i >> 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos_hi_q <= 1'b0;
    end else begin
      pos_hi_q <= pos_hi_d;
    end
  end

  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      neg_hi_q <= 1'b0;
    end else begin
      neg_hi_q <= pos_hi_q;
    end
  end

  // Gating on state keeps the output low right after reset, before neg_hi clears.
  assign clk_out_o = (state_q_i != IDLE) & (pos_hi_q | (cur_div_q_i[0] & neg_hi_q));

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer divider: control FSM, period counter and divisor staging.
//
//   state | meaning
//   IDLE  | stopped, cnt held at 0, clk_out low
//   RUN   | counting periods 0..cur_div-1
//   DRAIN | enable dropped; finishing the current period, then IDLE
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int          WIDTH       = 30,
  parameter int unsigned DEFAULT_DIV = 2000001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             div_err_q, div_err_d;
  logic             load_ok;
  logic             boundary;

  assign load_ok   = div_load && div_legal(64'(div_in));
  assign div_err_d = div_load && !div_legal(64'(div_in));
  assign boundary  = (state_q != IDLE) && (cnt_q == cur_div_q - WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      IDLE: begin
        if (load_ok) cur_div_d = div_in;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (enable) state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
      // The boundary consumes the older pending value; a coincident load waits a period.
      if (boundary && pend_valid_q) begin
        cur_div_d    = pend_div_q;
        pend_valid_d = 1'b0;
      end
      if (load_ok) begin
        pend_div_d   = div_in;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DEF_DIV;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      div_err_q    <= div_err_d;
    end
  end

  clk_div_duty #(
    .WIDTH(WIDTH)
  ) u_duty (
    .clk_i       (clk),
    .reset_i     (reset),
    .state_d_i   (state_d),
    .state_q_i   (state_q),
    .cnt_d_i     (cnt_d),
    .cur_div_d_i (cur_div_d),
    .cur_div_q_i (cur_div_q),
    .clk_out_o   (clk_out)
  );

  assign running  = (state_q != IDLE);
  assign tick     = running && (cnt_q == '0);
  assign div_busy = pend_valid_q;
  assign div_err  = div_err_q;
  assign cur_div  = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed vector table, corner sequences and randomized traffic vs a period model.
module tb_clk_div_prog;

  localparam int          W   = 30;
  localparam int unsigned DEF = 2000001;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_busy, div_err, clk_out, tick, running;
  logic [W-1:0] cur_div;

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .div_in   (div_in),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .cur_div  (cur_div)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Period-level model: mode 0 stopped, 1 running, 2 finishing last period.
  int          m_mode;
  int unsigned m_pos, m_div, m_pend;
  bit          m_has_pend, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit ld, input int unsigned din);
    bit legal, eop;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_div = DEF; m_has_pend = 0; m_err = 0;
      return;
    end
    legal = ld && (din >= 2);
    m_err = ld && (din < 2);
    if (m_mode == 0) begin
      if (legal) m_div = din;
      m_pos = 0;
      if (en) m_mode = 1;
    end else begin
      eop   = (m_pos == m_div - 1);
      m_pos = eop ? 0 : m_pos + 1;
      if (eop && m_has_pend) begin
        m_div      = m_pend;
        m_has_pend = 0;
      end
      if (m_mode == 1) m_mode = en ? 1 : 2;
      else if (en) m_mode = 1;
      else if (eop) m_mode = 0;
      if (legal) begin
        m_pend     = din;
        m_has_pend = 1;
      end
    end
  endtask

  function automatic bit exp_clk(input int h);
    return (m_mode != 0) && (2 * m_pos + h < m_div);
  endfunction

  task automatic go(input bit rst, input bit en, input bit ld, input int unsigned din);
    reset    = rst;
    enable   = en;
    div_load = ld;
    div_in   = W'(din);
    @(posedge clk);
    model_step(rst, en, ld, din);
    #1;
  endtask

  task automatic check_model();
    chk("tick",     32'(tick),     32'(m_mode != 0 && m_pos == 0));
    chk("running",  32'(running),  32'(m_mode != 0));
    chk("div_busy", 32'(div_busy), 32'(m_has_pend));
    chk("div_err",  32'(div_err),  32'(m_err));
    chk("cur_div",  32'(cur_div),  m_div);
    chk("clk_out_rise_half", 32'(clk_out), 32'(exp_clk(0)));
    @(negedge clk);
    #1;
    chk("clk_out_fall_half", 32'(clk_out), 32'(exp_clk(1)));
  endtask

  task automatic step(input bit rst, input bit en, input bit ld, input int unsigned din);
    go(rst, en, ld, din);
    check_model();
  endtask

  task automatic run_n(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, en, 0, 0);
  endtask

  task automatic run_until_pos(input int unsigned p, input bit en);
    for (int i = 0; i < 64 && m_pos != p; i++) step(0, en, 0, 0);
    if (m_pos != p) begin
      checks++; errors++;
      $display("FAIL run_until_pos: position %0d not reached", p);
    end
  endtask

  task automatic wait_applied();
    for (int i = 0; i < 64 && m_has_pend; i++) step(0, 1, 0, 0);
    if (m_has_pend) begin
      checks++; errors++;
      $display("FAIL wait_applied: pending divisor never applied");
    end
  endtask

  typedef struct {
    bit          en;
    bit          ld;
    int unsigned din;
    bit          tick;
    bit          run;
    bit          busy;
    bit          err;
    int unsigned cur;
    bit          clk0;
    bit          clk1;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // en ld din | tick run busy err cur | clk first-half, second-half
    tbl[0]  = '{0, 1, 4, 0, 0, 0, 0, 4, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 1, 0, 0, 4, 1, 1};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 4, 1, 1};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 0, 4, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 0, 0, 4, 0, 0};
    tbl[5]  = '{1, 0, 0, 1, 1, 0, 0, 4, 1, 1};
    tbl[6]  = '{1, 1, 3, 0, 1, 1, 0, 4, 1, 1};
    tbl[7]  = '{1, 0, 0, 0, 1, 1, 0, 4, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 1, 0, 4, 0, 0};
    tbl[9]  = '{1, 0, 0, 1, 1, 0, 0, 3, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 0, 0, 3, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 0, 3, 0, 0};
    tbl[12] = '{1, 0, 0, 1, 1, 0, 0, 3, 1, 1};
    tbl[13] = '{1, 1, 0, 0, 1, 0, 1, 3, 1, 0};
    tbl[14] = '{1, 1, 1, 0, 1, 0, 1, 3, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 1, 0, 0, 3, 1, 1};
    tbl[16] = '{0, 0, 0, 0, 1, 0, 0, 3, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 1, 0, 0, 3, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0};

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Directed table: N=4 then N=3 staged mid-period, bad loads, drain to idle
    for (int i = 0; i < 19; i++) begin
      go(0, tbl[i].en, tbl[i].ld, tbl[i].din);
      chk("tbl_tick",     32'(tick),     32'(tbl[i].tick));
      chk("tbl_running",  32'(running),  32'(tbl[i].run));
      chk("tbl_div_busy", 32'(div_busy), 32'(tbl[i].busy));
      chk("tbl_div_err",  32'(div_err),  32'(tbl[i].err));
      chk("tbl_cur_div",  32'(cur_div),  tbl[i].cur);
      chk("tbl_clk_rise_half", 32'(clk_out), 32'(tbl[i].clk0));
      @(negedge clk);
      #1;
      chk("tbl_clk_fall_half", 32'(clk_out), 32'(tbl[i].clk1));
    end

    // N=8, load 5 at cnt=2
    step(0, 0, 1, 8);
    step(0, 1, 0, 0);
    run_until_pos(2, 1);
    step(0, 1, 1, 5);
    run_n(20, 1);

    // Two loads in one N=8 period, then a load coincident with the boundary
    step(0, 1, 1, 8);
    wait_applied();
    run_until_pos(1, 1);
    step(0, 1, 1, 6);
    run_until_pos(3, 1);
    step(0, 1, 1, 10);
    run_n(25, 1);
    step(0, 1, 1, 8);
    wait_applied();
    run_until_pos(7, 1);
    step(0, 1, 1, 4);
    run_n(20, 1);

    // N=6 drain, then drain aborted by re-enable at cnt=4
    step(0, 1, 1, 6);
    wait_applied();
    run_until_pos(1, 1);
    run_n(10, 0);
    step(0, 1, 0, 0);
    run_until_pos(1, 1);
    run_until_pos(4, 0);
    run_n(14, 1);

    // Illegal loads, then reset at cnt=3 of N=7
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    step(0, 1, 1, 7);
    wait_applied();
    run_until_pos(3, 1);
    step(0, 1, 1, 9);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit          r, e, l;
      int unsigned d;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 12);
      step(r, e, l, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
